// File: rtl/dcache_if.sv
// Memory-stage bundle between the MIPS datapath, the data cache and main memory.
// The slave modport is the cache's view; the master modport is the pipeline/memory side.
interface dcache_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        CacheStallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  MemReadM, MemWriteM, ALUOutM, WriteDataM, mem_rdata, mem_ack,
    output ReadDataM, CacheStallM, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output MemReadM, MemWriteM, ALUOutM, WriteDataM, mem_rdata, mem_ack,
    input  ReadDataM, CacheStallM, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MIPS Memory stage.
// Misses refill a whole line word by word; stores always go to memory and update the line on a hit.
module dcache #(
  parameter int NSETS = 16,
  parameter int WORDS = 4
) (
  input  logic     clk,
  input  logic     reset,
  dcache_if.slave  bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_e;

  state_e             state_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [NSETS-1:0]   valid_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [TAG_W-1:0]   tag_q  [NSETS];
  logic [31:0]        data_q [NSETS*WORDS];

  logic [OFF_W-1:0]   offset;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               ack;
  logic               last_word;
  logic               unused_addr_bits;

  assign offset    = bus.ALUOutM[OFF_W+1:2];
  assign idx       = bus.ALUOutM[OFF_W+IDX_W+1:OFF_W+2];
  assign tag       = bus.ALUOutM[31:OFF_W+IDX_W+2];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign ack       = mem_req_q && bus.mem_ack;
  assign last_word = (cnt_q == OFF_W'(WORDS - 1));
  assign unused_addr_bits = ^bus.ALUOutM[1:0];

  // Control: state, refill counter, valid bits and the registered memory strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.MemWriteM) begin
            state_q   <= WRITE;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
          end else if (bus.MemReadM && !hit) begin
            state_q   <= REFILL;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
          end
        end
        REFILL: begin
          if (ack) begin
            cnt_q <= cnt_q + OFF_W'(1);
            // Line becomes visible only once every word has landed.
            if (last_word) begin
              valid_q[idx] <= 1'b1;
              state_q      <= IDLE;
              mem_req_q    <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid_q alone decides what is visible.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && ack) begin
      data_q[{idx, cnt_q}] <= bus.mem_rdata;
      if (last_word) tag_q[idx] <= tag;
    end else if (state_q == WRITE && ack && hit) begin
      data_q[{idx, offset}] <= bus.WriteDataM;
    end
  end

  always_comb begin
    bus.CacheStallM = 1'b0;
    case (state_q)
      IDLE:          bus.CacheStallM = bus.MemWriteM || (bus.MemReadM && !hit);
      REFILL, WRITE: bus.CacheStallM = 1'b1;
      default:       bus.CacheStallM = 1'b0;
    endcase
  end

  always_comb begin
    bus.mem_addr = '0;
    if (mem_req_q) begin
      if (mem_we_q) bus.mem_addr = {bus.ALUOutM[31:2], 2'b00};
      else          bus.mem_addr = {tag, idx, cnt_q, 2'b00};
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = (mem_req_q && mem_we_q) ? bus.WriteDataM : 32'h0;
  assign bus.ReadDataM = hit ? data_q[{idx, offset}] : 32'h0;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a latency-programmable memory model plus hand-computed expectations.
module tb_dcache;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   lat   = 0;
  int   wait_cnt;
  int   rd_acks = 0;
  int   snap;
  int   n;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  dcache_if bus ();

  dcache #(.NSETS(16), .WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x40..0x4C hold 0xA0..0xA3, everything else reads {16'h5A5A, addr[15:0]}.
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a >= 32'h40 && a <= 32'h4C) return 32'hA0 + ((a - 32'h40) >> 2);
    return {16'h5A5A, a[15:0]};
  endfunction

  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= lat);
  assign bus.mem_rdata = model_rd(bus.mem_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack && !bus.mem_we) rd_acks <= rd_acks + 1;
    if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
      wr_addr <= bus.mem_addr;
      wr_data <= bus.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stalled cycles until the cache releases the pipeline; bounded.
  task automatic run_stall(output int cnt);
    cnt = 0;
    while (bus.CacheStallM === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ALUOutM    = 32'h0;
    bus.WriteDataM = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", bus.CacheStallM, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    reset = 1'b1;
    tick();
    chk("idle_stall", bus.CacheStallM, 0);
    chk("idle_rdata", bus.ReadDataM, 0);
    chk("idle_we", bus.mem_we, 0);

    // Cold load from 0x40 with immediate ack
    bus.MemReadM = 1'b1;
    bus.ALUOutM  = 32'h40;
    #1;
    chk("miss_c1_stall", bus.CacheStallM, 1);
    chk("miss_c1_req", bus.mem_req, 0);
    chk("miss_c1_rdata", bus.ReadDataM, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("refill_stall", bus.CacheStallM, 1);
      chk("refill_req", bus.mem_req, 1);
      chk("refill_we", bus.mem_we, 0);
      chk("refill_addr", bus.mem_addr, 32'h40 + 32'(4 * k));
    end
    tick();
    chk("c6_stall", bus.CacheStallM, 0);
    chk("c6_rdata", bus.ReadDataM, 32'hA0);
    chk("c6_req", bus.mem_req, 0);
    bus.ALUOutM = 32'h48;
    #1;
    chk("hit48_stall", bus.CacheStallM, 0);
    chk("hit48_rdata", bus.ReadDataM, 32'hA2);

    // Store hit to 0x44, ack on the third request cycle
    tick();
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b1;
    bus.ALUOutM    = 32'h44;
    bus.WriteDataM = 32'hDEADBEEF;
    lat = 2;
    #1;
    chk("st_c1_stall", bus.CacheStallM, 1);
    chk("st_c1_req", bus.mem_req, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_stall", bus.CacheStallM, 1);
      chk("st_we", bus.mem_we, 1);
      chk("st_addr", bus.mem_addr, 32'h44);
      chk("st_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("st_ack", bus.mem_ack, 32'(k == 2));
    end
    tick();
    chk("st_done_stall", bus.CacheStallM, 0);
    chk("st_done_req", bus.mem_req, 0);
    chk("st_done_addr", bus.mem_addr, 0);
    chk("st_mem_addr", wr_addr, 32'h44);
    chk("st_mem_data", wr_data, 32'hDEADBEEF);
    tick();
    bus.MemWriteM = 1'b0;
    bus.MemReadM  = 1'b1;
    #1;
    chk("ld44_stall", bus.CacheStallM, 0);
    chk("ld44_rdata", bus.ReadDataM, 32'hDEADBEEF);

    // Store miss to 0x1000: memory write only, then a load refills
    tick();
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b1;
    bus.ALUOutM    = 32'h1000;
    bus.WriteDataM = 32'h12345678;
    lat = 0;
    #1;
    chk("stm_c1_stall", bus.CacheStallM, 1);
    tick();
    chk("stm_we", bus.mem_we, 1);
    chk("stm_addr", bus.mem_addr, 32'h1000);
    chk("stm_ack", bus.mem_ack, 1);
    tick();
    chk("stm_done_stall", bus.CacheStallM, 0);
    chk("stm_mem_addr", wr_addr, 32'h1000);
    chk("stm_mem_data", wr_data, 32'h12345678);
    tick();
    bus.MemWriteM = 1'b0;
    bus.MemReadM  = 1'b1;
    #1;
    chk("ld1000_miss", bus.CacheStallM, 1);
    snap = rd_acks;
    run_stall(n);
    chk("ld1000_stalls", n, 5);
    chk("ld1000_acks", rd_acks - snap, 4);
    chk("ld1000_rdata", bus.ReadDataM, 32'h5A5A1000);

    // Conflict on index 4: 0x140 evicts 0x40
    bus.ALUOutM = 32'h40;
    #1;
    chk("ld40_hit_stall", bus.CacheStallM, 0);
    chk("ld40_hit_rdata", bus.ReadDataM, 32'hA0);
    bus.ALUOutM = 32'h140;
    #1;
    chk("ld140_miss", bus.CacheStallM, 1);
    run_stall(n);
    chk("ld140_stalls", n, 5);
    chk("ld140_rdata", bus.ReadDataM, 32'h5A5A0140);
    bus.ALUOutM = 32'h40;
    #1;
    chk("ld40_evicted", bus.CacheStallM, 1);
    run_stall(n);
    chk("ld40_stalls", n, 5);
    chk("ld40_rdata", bus.ReadDataM, 32'hA0);

    // Reset pulsed after two refill acks
    bus.ALUOutM = 32'h200;
    #1;
    chk("ld200_miss", bus.CacheStallM, 1);
    tick();
    chk("ld200_w0", bus.mem_addr, 32'h200);
    tick();
    chk("ld200_w1", bus.mem_addr, 32'h204);
    tick();
    chk("ld200_w2", bus.mem_addr, 32'h208);
    reset = 1'b0;
    #1;
    chk("abort_req", bus.mem_req, 0);
    chk("abort_addr", bus.mem_addr, 0);
    chk("abort_rdata", bus.ReadDataM, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("relaunch_stall", bus.CacheStallM, 1);
    snap = rd_acks;
    run_stall(n);
    chk("ld200_stalls", n, 5);
    chk("ld200_acks", rd_acks - snap, 4);
    chk("ld200_rdata", bus.ReadDataM, 32'h5A5A0200);
    bus.ALUOutM = 32'h40;
    #1;
    chk("ld40_after_rst", bus.CacheStallM, 1);
    bus.MemReadM = 1'b0;
    #1;
    chk("final_idle", bus.CacheStallM, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
